// File: rtl/alu_pkg.sv
// ------------------------------------------------------------------
// alu_pkg: opcodes, FSM encoding and shift-width helper for iter_alu
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_XLEN_DEFAULT = 32;

  localparam logic [4:0] OP_AND    = 5'b00000;
  localparam logic [4:0] OP_OR     = 5'b00001;
  localparam logic [4:0] OP_ADD    = 5'b00010;
  localparam logic [4:0] OP_SLL    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b00110;
  localparam logic [4:0] OP_XOR    = 5'b00111;
  localparam logic [4:0] OP_SRL    = 5'b01000;
  localparam logic [4:0] OP_SRA    = 5'b01001;
  localparam logic [4:0] OP_SLT    = 5'b01010;
  localparam logic [4:0] OP_SLTU   = 5'b01011;
  localparam logic [4:0] OP_MUL    = 5'b10000;
  localparam logic [4:0] OP_MULH   = 5'b10001;
  localparam logic [4:0] OP_MULHSU = 5'b10010;
  localparam logic [4:0] OP_MULHU  = 5'b10011;
  localparam logic [4:0] OP_DIV    = 5'b10100;
  localparam logic [4:0] OP_DIVU   = 5'b10101;
  localparam logic [4:0] OP_REM    = 5'b10110;
  localparam logic [4:0] OP_REMU   = 5'b10111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Shift amount width derived from the operand width.
  function automatic int shamt_width(input int xlen);
    return $clog2(xlen);
  endfunction

  function automatic logic is_simple_op(input logic [4:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SUB, OP_XOR,
                      OP_SRL, OP_SRA, OP_SLT, OP_SLTU};
  endfunction

  function automatic logic is_muldiv_op(input logic [4:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                      OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

`default_nettype wire

// File: rtl/iter_muldiv_unit.sv
// ------------------------------------------------------------------
// iter_muldiv_unit: XLEN-cycle shift-add multiplier / restoring divider
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module iter_muldiv_unit
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic [XLEN-1:0] hi_q, lo_q, m_q, a_lat;
  logic            div_q, hi_sel_q, neg_q, div0_q;

  logic            s_div, s_hi_sel, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] a_mag, b_mag;

  assign s_div    = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign s_hi_sel = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
  assign a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  assign b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
  assign sa       = a_signed & a[XLEN-1];
  assign sb       = b_signed & b[XLEN-1];
  assign a_mag    = sa ? -a : a;
  assign b_mag    = sb ? -b : b;

  // The start edge already performs the first step on the incoming
  // magnitudes, so the result is ready after exactly XLEN edges.
  logic [XLEN-1:0] src_hi, src_lo, src_m, hi_n, lo_n, rdiff;
  logic [XLEN:0]   sum, rsh;
  logic            src_div, ge;

  always_comb begin
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? (s_div ? a_mag : b_mag) : lo_q;
    src_m   = start ? (s_div ? b_mag : a_mag) : m_q;
    src_div = start ? s_div : div_q;
    sum     = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_m} : '0);
    rsh     = {src_hi, src_lo[XLEN-1]};
    ge      = (rsh >= {1'b0, src_m});
    rdiff   = rsh[XLEN-1:0] - src_m;
    if (src_div) begin
      hi_n = ge ? rdiff : rsh[XLEN-1:0];
      lo_n = {src_lo[XLEN-2:0], ge};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], src_lo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      a_lat    <= '0;
      div_q    <= 1'b0;
      hi_sel_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= CW'(1);
      hi_q     <= hi_n;
      lo_q     <= lo_n;
      m_q      <= src_m;
      a_lat    <= a;
      div_q    <= s_div;
      hi_sel_q <= s_hi_sel;
      neg_q    <= (s_div && s_hi_sel) ? sa : (sa ^ sb);
      div0_q   <= s_div && (b == '0);
    end else if (busy_q) begin
      if (cnt_q == CW'(XLEN)) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        hi_q  <= hi_n;
        lo_q  <= lo_n;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(XLEN));

  logic [2*XLEN-1:0] prod_n;

  always_comb begin
    prod_n = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    if (div_q) begin
      if (hi_sel_q) result = div0_q ? a_lat : (neg_q ? -hi_q : hi_q);
      else          result = div0_q ? '1    : (neg_q ? -lo_q : lo_q);
    end else begin
      result = hi_sel_q ? prod_n[2*XLEN-1:XLEN] : prod_n[XLEN-1:0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/iter_alu.sv
// ------------------------------------------------------------------
// iter_alu: handshaked ALU; mul/div enabled by macro ITER_ALU_MULDIV_EN
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module iter_alu
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_in_2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic [2:0]      alu_bcond,
  output logic            illegal
);

  localparam int SHW = shamt_width(XLEN);

  state_t          state, state_next;
  logic            op_md, op_illegal, load, ill_next;
  logic            md_busy, md_done;
  logic [XLEN-1:0] md_result, simple_result, res_next;
  logic [SHW-1:0]  shamt;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign shamt     = alu_in_2[SHW-1:0];

`ifdef ITER_ALU_MULDIV_EN
  assign op_md = is_muldiv_op(alu_op);

  iter_muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (in_valid & in_ready & op_md),
    .op     (alu_op),
    .a      (alu_in_1),
    .b      (alu_in_2),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );
`else
  assign op_md     = 1'b0;
  assign md_busy   = 1'b0;
  assign md_done   = 1'b0;
  assign md_result = '0;
`endif

  assign op_illegal = ~is_simple_op(alu_op) & ~op_md;

  always_comb begin
    simple_result = '0;
    case (alu_op)
      OP_AND:  simple_result = alu_in_1 & alu_in_2;
      OP_OR:   simple_result = alu_in_1 | alu_in_2;
      OP_ADD:  simple_result = alu_in_1 + alu_in_2;
      OP_SUB:  simple_result = alu_in_1 - alu_in_2;
      OP_XOR:  simple_result = alu_in_1 ^ alu_in_2;
      OP_SLL:  simple_result = alu_in_1 << shamt;
      OP_SRL:  simple_result = alu_in_1 >> shamt;
      OP_SRA:  simple_result = XLEN'($signed(alu_in_1) >>> shamt);
      OP_SLT:  simple_result = {{(XLEN-1){1'b0}}, $signed(alu_in_1) < $signed(alu_in_2)};
      OP_SLTU: simple_result = {{(XLEN-1){1'b0}}, alu_in_1 < alu_in_2};
      default: simple_result = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    res_next   = simple_result;
    ill_next   = op_illegal;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (op_md) begin
            state_next = ST_BUSY;
          end else begin
            state_next = ST_DONE;
            load       = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (md_busy && md_done) begin
          state_next = ST_DONE;
          load       = 1'b1;
          res_next   = md_result;
          ill_next   = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Flags are taken from the value that becomes the registered result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      alu_result <= '0;
      alu_bcond  <= 3'b000;
      illegal    <= 1'b0;
    end else begin
      state <= state_next;
      if (load) begin
        alu_result <= res_next;
        alu_bcond  <= {~res_next[XLEN-1] & (|res_next), res_next[XLEN-1], ~(|res_next)};
        illegal    <= ill_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; power of two, 8..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block accepts request this cycle.
REQ-006 SHALL have port alu_op  input  5  operation code per REQ-012.
REQ-007 SHALL have ports alu_in_1, alu_in_2  input  XLEN each  operands.
REQ-008 SHALL have port out_valid  output  1  result valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port alu_result  output  XLEN  registered result.
REQ-011 SHALL have ports alu_bcond  output  3  {result>0 signed, result<0 signed, result==0}, bits [2:0]; and illegal  output  1  unsupported alu_op.

Function
REQ-012 SHALL decode alu_op: 00000 AND, 00001 OR, 00010 ADD, 00110 SUB, 00011 SLL, 00111 XOR, 01000 SRL, 01001 SRA, 01010 SLT, 01011 SLTU, 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; all others illegal.
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; in_ready = (state==IDLE); request accepted when in_valid & in_ready.
REQ-014 SHALL, for simple ops (00000-01011) and illegal ops, go IDLE->DONE; out_valid asserts the cycle after acceptance (latency 1).
REQ-015 SHALL, for mul/div ops, go IDLE->BUSY, iterate exactly XLEN cycles, then ->DONE; out_valid asserts XLEN+1 cycles after acceptance, independent of operand values.
REQ-016 SHALL hold alu_result, alu_bcond, illegal stable in DONE until out_valid & out_ready, then return to IDLE the next cycle.
REQ-017 SHALL use only alu_in_2[log2(XLEN)-1:0] as shift amount; SRA sign-fills; SLT/SLTU yield 0 or 1.
REQ-018 SHALL wrap ADD/SUB/MUL modulo 2^XLEN; MULH/MULHSU/MULHU return upper XLEN bits of 2*XLEN product with RV-M signedness.
REQ-019 SHALL on divide-by-zero return quotient all-ones and remainder = alu_in_1 (DIV, DIVU, REM, REMU).
REQ-020 SHALL on signed overflow (DIV/REM of most-negative by -1) return quotient = alu_in_1, remainder 0.
REQ-021 SHALL on illegal op return alu_result 0, illegal=1; illegal=0 for all legal ops.
REQ-022 SHALL ignore in_valid and operand changes while BUSY or DONE; operands latched at acceptance.
REQ-023 SHALL compute alu_bcond from the final registered alu_result.

Reset
REQ-024 SHALL, with reset high at a clock edge, enter IDLE and clear alu_result, alu_bcond, illegal, out_valid, iteration counter; in_ready=1 next cycle.
REQ-025 SHALL abort any BUSY or DONE operation on reset with no result delivered; reset dominates in_valid.

Configuration
REQ-026 SHALL provide macro ITER_ALU_MULDIV_EN: defined -> mul/div ops per REQ-015..020; undefined -> codes 1xxxx treated illegal (latency 1, result 0, illegal=1), multiply/divide datapath absent.

Structure
REQ-027 SHALL place alu_op code constants, FSM state encoding and XLEN-derived shift-width constant in shared package alu_pkg.
REQ-028 SHALL implement iterative shift-add multiply and restoring divide in sub-module iter_muldiv_unit (start/busy/done, XLEN-cycle), instantiated only under ITER_ALU_MULDIV_EN.

Verification
REQ-029 SHALL test ADD 0x7FFFFFFF+1, XLEN=32 -> out_valid 1 cycle later, result 0x80000000, alu_bcond=3'b010.
REQ-030 SHALL test SUB 5-5 with out_ready low 3 cycles -> result 0, alu_bcond=3'b001 held stable, in_ready=0 until handshake.
REQ-031 SHALL test MULH 0xFFFFFFFF*0xFFFFFFFF -> result 0 after exactly 33 cycles; MULHU same operands -> 0xFFFFFFFE.
REQ-032 SHALL test DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REMU 7/0 -> 7; DIVU 7/0 -> 0xFFFFFFFF.
REQ-033 SHALL test reset asserted mid-BUSY (cycle 10 of DIV) -> next cycle IDLE, out_valid=0, in_ready=1, no stale result later.
REQ-034 SHALL test alu_op 11111, and MUL with ITER_ALU_MULDIV_EN undefined -> latency 1, result 0, illegal=1.
